// File: rtl/float_mul_rr_sched.sv
// Round-robin scheduler sharing one combinational float multiplier among
// NREQ requesters. Operand pairs are registered into S0 (which drives the
// multiplier), and the product plus requester ID is registered into S1.
module float_mul_rr_sched #(
  parameter int NREQ  = 4,
  parameter int IDW   = 2,
  parameter int WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [WIDTH-1:0]      mul_c,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_c,
  output logic [IDW-1:0]        out_id
);

  // Issue stage (S0) state and the round-robin pointer.
  logic             s0_valid;
  logic [IDW-1:0]   s0_id;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic [IDW-1:0]   ptr;

  // Arbitration results.
  logic             adv;
  logic             grant_found;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   ptr_next;
  logic [WIDTH-1:0] grant_a;
  logic [WIDTH-1:0] grant_b;

  // The whole pipeline moves only when S1 is empty or being drained.
  assign adv = ~out_valid | out_ready;

  // The multiplier always sees the S0 operands.
  assign mul_a = s0_a;
  assign mul_b = s0_b;

  // Round-robin search: first valid index at or above ptr, else the first
  // valid index below it. Only constant indices are used, so the search
  // unrolls into a plain priority chain that is off the multiplier path.
  always_comb begin
    // NOTE: every combinational output gets a default first so that no path
    // through the block leaves it unassigned and a latch is never inferred.
    grant_found = 1'b0;
    grant       = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i] && (IDW'(i) >= ptr)) begin
        grant_found = 1'b1;
        grant       = IDW'(i);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (!grant_found && req_valid[i]) begin
        grant_found = 1'b1;
        grant       = IDW'(i);
      end
    end
  end

  // Select the granted operand pair and compute the wrapped next pointer.
  always_comb begin
    grant_a = '0;
    grant_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        grant_a = req_a[i*WIDTH +: WIDTH];
        grant_b = req_b[i*WIDTH +: WIDTH];
      end
    end
    ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + IDW'(1);
  end

  // One-hot ready to the granted requester, suppressed while frozen or in reset.
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = rst_n & adv & grant_found & (grant == IDW'(i));
    end
  end

  // S0 issue register and round-robin pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: data registers are reset as well as the valid bits, so no stale
    // operand or product is ever visible on the ports after a reset.
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_id    <= '0;
      s0_a     <= '0;
      s0_b     <= '0;
      ptr      <= '0;
    end else if (adv) begin
      // NOTE: registers use non-blocking assignments so every stage samples
      // the values from before the edge, independent of statement order.
      s0_valid <= grant_found;
      if (grant_found) begin
        s0_id <= grant;
        s0_a  <= grant_a;
        s0_b  <= grant_b;
        ptr   <= ptr_next;
      end
    end
  end

  // S1 output register captures the product of whatever S0 held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_id    <= '0;
      out_c     <= '0;
    end else if (adv) begin
      out_valid <= s0_valid;
      out_id    <= s0_id;
      out_c     <= mul_c;
    end
  end

endmodule

// File: tb/tb_float_mul_rr_sched.sv
// Directed bench for float_mul_rr_sched: a vector table of single requests
// plus hand-written round-robin, backpressure, pointer-wrap and reset runs.
module tb_float_mul_rr_sched;

  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int W    = 32;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [W-1:0]      mul_a;
  logic [W-1:0]      mul_b;
  logic [W-1:0]      mul_c;
  logic              out_valid;
  logic              out_ready;
  logic [W-1:0]      out_c;
  logic [IDW-1:0]    out_id;

  int n_tests = 0;
  int n_fail  = 0;

  float_mul_rr_sched #(.NREQ(NREQ), .IDW(IDW), .WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_c     (mul_c),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_c     (out_c),
    .out_id    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple truncating multiplier for normal operands; zero in gives zero out.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    logic [47:0] p;
    int          e;
    logic [22:0] f;
    logic [7:0]  eb;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      e = e + 1;
      f = p[46:24];
    end else begin
      f = p[45:23];
    end
    eb = e[7:0];
    return {s, eb, f};
  endfunction

  assign mul_c = fmul(mul_a, mul_b);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  typedef struct {
    int          id;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
  } vec_t;

  vec_t        vecs[6];
  logic [31:0] bp_c[4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NREQ-1:0] onehot;
    logic [31:0]     held_c;
    logic [IDW-1:0]  held_id;
    int issued, got, stall_cnt;
    int exp_grant[4];
    int exp_ptr[4];

    vecs[0] = '{2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000}; // 2.0 * 3.0
    vecs[1] = '{0, 32'h3FC0_0000, 32'hC000_0000, 32'hC040_0000}; // 1.5 * -2.0
    vecs[2] = '{1, 32'h0000_0000, 32'h40A0_0000, 32'h0000_0000}; // 0 * 5.0
    vecs[3] = '{3, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000}; // 1.0 * 1.0
    vecs[4] = '{1, 32'h3F00_0000, 32'h4080_0000, 32'h4000_0000}; // 0.5 * 4.0
    vecs[5] = '{3, 32'hBFC0_0000, 32'hBFC0_0000, 32'h4010_0000}; // -1.5 * -1.5

    // Reset state, with requesters already asserting valid.
    rst_n     = 1'b0;
    req_a     = '0;
    req_b     = '0;
    out_ready = 1'b1;
    req_valid = 4'hF;
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_mul_a", mul_a, 32'h0);
    check("rst_out_c", out_c, 32'h0);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Vector table: one request at a time, accept then result one edge later.
    for (int v = 0; v < 6; v++) begin
      set_req(vecs[v].id, vecs[v].a, vecs[v].b);
      req_valid = '0;
      req_valid[vecs[v].id] = 1'b1;
      onehot = '0;
      onehot[vecs[v].id] = 1'b1;
      #1;
      check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(onehot));
      tick();
      req_valid = '0;
      tick();
      check($sformatf("vec%0d_valid", v), 32'(out_valid), 32'h1);
      check($sformatf("vec%0d_c", v), out_c, vecs[v].c);
      check($sformatf("vec%0d_id", v), 32'(out_id), 32'(vecs[v].id));
      tick();
      check($sformatf("vec%0d_drop", v), 32'(out_valid), 32'h0);
    end

    // Round-robin with every requester continuously valid.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h3FC0_0000, 32'hC000_0000);
    req_valid = 4'hF;
    tick();
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("rr%0d_valid", k), 32'(out_valid), 32'h1);
      check($sformatf("rr%0d_id", k), 32'(out_id), 32'(k % NREQ));
      check($sformatf("rr%0d_c", k), out_c, 32'hC040_0000);
    end
    req_valid = '0;
    tick();
    tick();
    check("rr_drain", 32'(out_valid), 32'h0);

    // Backpressure: stall 5 cycles once a result is pending, scoreboard after.
    do_reset();
    set_req(0, 32'h3F80_0000, 32'h4000_0000); bp_c[0] = 32'h4000_0000;
    set_req(1, 32'h3FC0_0000, 32'h4000_0000); bp_c[1] = 32'h4040_0000;
    set_req(2, 32'h4000_0000, 32'h4000_0000); bp_c[2] = 32'h4080_0000;
    set_req(3, 32'h4040_0000, 32'h4000_0000); bp_c[3] = 32'h40C0_0000;
    issued    = 0;
    got       = 0;
    stall_cnt = 0;
    held_c    = '0;
    held_id   = '0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      req_valid = (issued < 8) ? 4'hF : 4'h0;
      out_ready = !(out_valid && stall_cnt < 5);
      #1;
      if (!out_ready) begin
        if (stall_cnt == 0) begin
          held_c  = out_c;
          held_id = out_id;
        end else begin
          check($sformatf("bp_hold_c%0d", stall_cnt), out_c, held_c);
          check($sformatf("bp_hold_id%0d", stall_cnt), 32'(out_id), 32'(held_id));
        end
        check($sformatf("bp_ready%0d", stall_cnt), 32'(req_ready), 32'h0);
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_id%0d", got), 32'(out_id), 32'(got % NREQ));
        check($sformatf("bp_c%0d", got), out_c, bp_c[got % NREQ]);
        got++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) issued++;
      end
      tick();
    end
    check("bp_count", 32'(got), 32'd8);
    check("bp_stalls", 32'(stall_cnt), 32'd5);
    check("bp_empty", 32'(out_valid), 32'h0);
    out_ready = 1'b1;

    // Pointer skip and wrap: only requesters 1 and 3, starting from ptr = 2.
    do_reset();
    req_valid = 4'b0010;
    tick();
    check("ptr_start", 32'(dut.ptr), 32'd2);
    exp_grant = '{3, 1, 3, 1};
    exp_ptr   = '{0, 2, 0, 2};
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      onehot = '0;
      onehot[exp_grant[k]] = 1'b1;
      #1;
      check($sformatf("wrap%0d_grant", k), 32'(req_ready), 32'(onehot));
      tick();
      check($sformatf("wrap%0d_ptr", k), 32'(dut.ptr), 32'(exp_ptr[k]));
    end
    req_valid = '0;
    tick();
    tick();
    tick();

    // Reset mid-flight with both stages holding data.
    for (int i = 0; i < NREQ; i++) set_req(i, 32'h3FC0_0000, 32'hC000_0000);
    req_valid = 4'hF;
    tick();
    tick();
    check("mid_pre_s0", 32'(dut.s0_valid), 32'h1);
    check("mid_pre_out", 32'(out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'h0);
    check("mid_rst_ready", 32'(req_ready), 32'h0);
    tick();
    check("mid_rst_hold", 32'(out_valid), 32'h0);
    req_valid = 4'b1010;
    rst_n = 1'b1;
    #1;
    check("mid_first_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    check("mid_no_stale", 32'(out_valid), 32'h0);
    tick();
    check("mid_result_valid", 32'(out_valid), 32'h1);
    check("mid_result_id", 32'(out_id), 32'd1);
    check("mid_result_c", out_c, 32'hC040_0000);
    tick();
    check("mid_drain", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
